// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin memory arbiter.
// Provides the arbiter state enum, the core-count ceiling and clog2.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    localparam int MAX_CORES = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set req at/after ptr, wrapping.
// Ports: req[N], ptr -> onehot[N], idx (binary of onehot), any (req != 0).
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 1,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    int k;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!any && req[k]) begin
                any       = 1'b1;
                onehot[k] = 1'b1;
                idx       = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wb_rr_mem_arbiter.sv
// Round-robin Wishbone B3 classic arbiter: NUM_CORES masters -> one slave.
// Grant is held for a whole cyc; slave side is muxed from the registered grant.
// Ports: wb_clk_i, wb_rst_ni (async, active-low); m_* packed per master
// (cyc/stb/we/sel/adr/dat in, dat/ack/err out); s_* slave port; grant_o.
// Option WB_ARB_TIMEOUT_EN: watchdog errors a stalled access, adds timeout_o.
module wb_rr_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_CORES = 1,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic [NUM_CORES-1:0]      m_cyc_i,
    input  logic [NUM_CORES-1:0]      m_stb_i,
    input  logic [NUM_CORES-1:0]      m_we_i,
    input  logic [NUM_CORES*DW/8-1:0] m_sel_i,
    input  logic [NUM_CORES*AW-1:0]   m_adr_i,
    input  logic [NUM_CORES*DW-1:0]   m_dat_i,
    output logic [DW-1:0]             m_dat_o,
    output logic [NUM_CORES-1:0]      m_ack_o,
    output logic [NUM_CORES-1:0]      m_err_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [DW/8-1:0]           s_sel_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
`ifdef WB_ARB_TIMEOUT_EN
    output logic                      timeout_o,
`endif
    output logic [NUM_CORES-1:0]      grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_CORES > 1) ? clog2(NUM_CORES) : 1;

    arb_state_t           state_q, state_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        ptr_nxt;

    logic [NUM_CORES-1:0] pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;

    logic                 busy;
    logic                 g_cyc;
    logic                 act;
    logic                 to_hit;

    wb_rr_pick #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_pick (
        .req    (m_cyc_i),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign busy    = (state_q == ARB_BUSY);
    assign g_cyc   = busy & m_cyc_i[gidx_q];
    assign act     = g_cyc & ~to_hit;
    assign ptr_nxt = (int'(gidx_q) == NUM_CORES - 1) ? '0 : gidx_q + 1'b1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Release always passes through IDLE, so handover costs one cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                end
            end
            ARB_BUSY: begin
                if (!g_cyc || to_hit) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                end
            end
        endcase
    end

    // Everything toward the slave is gated by the granted master's cyc,
    // so an async reset or a dropped cyc aborts the access at once.
    always_comb begin
        s_cyc_o = act;
        s_stb_o = act & m_stb_i[gidx_q];
        s_we_o  = act & m_we_i[gidx_q];
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (act) begin
            s_sel_o = m_sel_i[int'(gidx_q)*SW +: SW];
            s_adr_o = m_adr_i[int'(gidx_q)*AW +: AW];
            s_dat_o = m_dat_i[int'(gidx_q)*DW +: DW];
        end
    end

    always_comb begin
        m_dat_o = busy ? s_dat_i : '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (act && s_ack_i) m_ack_o = grant_q;
        if ((g_cyc && s_err_i) || to_hit) m_err_o = grant_q;
    end

    assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       to_q;

    assign to_hit    = g_cyc && (wd_q == 8'(TIMEOUT));
    assign timeout_o = to_q;

    // Held at zero while IDLE, which covers the clear-on-grant case.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            if (!busy || s_ack_i || s_err_i) wd_q <= '0;
            else if (s_stb_o) wd_q <= wd_q + 8'd1;
            if (to_hit) to_q <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_mem_arbiter.sv
// Scoreboard bench for wb_rr_mem_arbiter, 4 masters, simple 1-wait slave.
// Expected grants and responses are queued at stimulus time, popped on output.
module tb_wb_rr_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*SW-1:0] m_sel;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0]   s_sel_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;
`ifdef WB_ARB_TIMEOUT_EN
    logic            timeout_o;
`endif

    bit          mcyc[N], mstb[N], mwe[N];
    logic [3:0]  msel[N];
    logic [31:0] madr[N], mdat[N];

    typedef struct {
        int          k;
        bit          err;
        bit          rd;
        logic [31:0] dat;
    } exp_t;

    exp_t        sbq[$];
    logic [N-1:0] gq[$];

    int checks = 0;
    int errors = 0;

    bit hang = 1'b0;
    bit err_mode = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            m_cyc[k]            = mcyc[k];
            m_stb[k]            = mstb[k];
            m_we[k]             = mwe[k];
            m_sel[k*SW +: SW]   = msel[k];
            m_adr[k*AW +: AW]   = madr[k];
            m_dat[k*DW +: DW]   = mdat[k];
        end
    end

    wb_rr_mem_arbiter #(
        .NUM_CORES (N),
        .AW        (AW),
        .DW        (DW),
        .TIMEOUT   (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_sel_i   (m_sel),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
`ifdef WB_ARB_TIMEOUT_EN
        .timeout_o (timeout_o),
`endif
        .grant_o   (grant_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_beats(input int k, input int beats, input logic [31:0] a,
                             input bit we, input bit err);
        exp_t e;
        for (int b = 0; b < beats; b++) begin
            e.k   = k;
            e.err = err;
            e.rd  = !we;
            e.dat = rdf(a + 32'(4 * b));
            sbq.push_back(e);
        end
    endtask

    task automatic mrun(input int k, input int beats, input logic [31:0] a,
                        input bit we, input int hold);
        int n = 0;
        int lim = 0;
        bit hit;
        mcyc[k] = 1'b1;
        mstb[k] = 1'b1;
        mwe[k]  = we;
        madr[k] = a;
        mdat[k] = a ^ 32'hDEAD_BEEF;
        msel[k] = 4'hF ^ 4'(1 << k);
        while (n < beats && lim < 3000) begin
            @(negedge clk);
            hit = m_ack_o[k] | m_err_o[k];
            @(posedge clk);
            #1;
            lim++;
            if (hit) begin
                n++;
                madr[k] = a + 32'(4 * n);
                mdat[k] = madr[k] ^ 32'hDEAD_BEEF;
            end
        end
        chk("beats", 64'(n), 64'(beats));
        mstb[k] = 1'b0;
        repeat (hold) sync();
        mcyc[k] = 1'b0;
        mwe[k]  = 1'b0;
    endtask

    task automatic wait_grant(input logic [N-1:0] want);
        int i = 0;
        @(negedge clk);
        while (grant_o != want && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("wait_grant", grant_o, want);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_scyc", s_cyc_o, 0);
        chk("rst_sstb", s_stb_o, 0);
        chk("rst_ack", m_ack_o, 0);
        chk("rst_err", m_err_o, 0);
`ifdef WB_ARB_TIMEOUT_EN
        chk("rst_timeout", timeout_o, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Slave: answers every stalled strobe in its second cycle.
    logic        na, ne;
    logic [31:0] nd;
    initial begin
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = '0;
        forever begin
            @(negedge clk);
            na = 1'b0;
            ne = 1'b0;
            nd = s_dat_i;
            if (rst_n && s_stb_o && !s_ack_i && !s_err_i && !hang) begin
                if (err_mode) ne = 1'b1;
                else na = 1'b1;
                nd = s_we_o ? '0 : rdf(s_adr_o);
            end
            @(posedge clk);
            #1;
            s_ack_i = na;
            s_err_i = ne;
            s_dat_i = nd;
        end
    end

    logic [N-1:0] prev_g = '0;
    always @(negedge clk) begin : mon
        exp_t         e;
        int           g;
        logic [N-1:0] oh;
        g = -1;
        for (int i = 0; i < N; i++) if (grant_o[i]) g = i;
        chk("onehot", ($countones(grant_o) <= 1), 1);
        if (grant_o != 0 && prev_g != 0 && grant_o != prev_g)
            chk("gap", grant_o, prev_g);
        if (grant_o != 0 && prev_g == 0) begin
            if (gq.size() == 0) chk("grant_unexp", grant_o, 0);
            else chk("grant", grant_o, gq.pop_front());
        end
        if (s_stb_o) begin
            if (g < 0) begin
                chk("stb_nogrant", s_stb_o, 0);
            end else begin
                chk("s_adr", s_adr_o, madr[g]);
                chk("s_sel", s_sel_o, msel[g]);
                chk("s_we", s_we_o, mwe[g]);
                if (s_we_o) chk("s_dat", s_dat_o, mdat[g]);
            end
        end
        if ((m_ack_o | m_err_o) != 0) begin
            if (sbq.size() == 0) begin
                chk("resp_unexp", m_ack_o | m_err_o, 0);
            end else begin
                e = sbq.pop_front();
                oh = '0;
                oh[e.k] = 1'b1;
                chk("ack", m_ack_o, e.err ? '0 : oh);
                chk("err", m_err_o, e.err ? oh : '0);
                if (e.rd && !e.err) chk("rdat", m_dat_o, e.dat);
            end
        end
        prev_g <= grant_o;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench hung");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            mcyc[k] = 1'b0;
            mstb[k] = 1'b0;
            mwe[k]  = 1'b0;
            msel[k] = '0;
            madr[k] = '0;
            mdat[k] = '0;
        end
        do_reset();
        sync();

        // single read from m1, grant one cycle after cyc
        gq.push_back(4'b0010);
        exp_beats(1, 1, 32'h0000_1010, 1'b0, 1'b0);
        fork
            mrun(1, 1, 32'h0000_1010, 1'b0, 0);
            begin
                @(negedge clk);
                chk("t1_idle_grant", grant_o, 0);
                chk("t1_idle_cyc", s_cyc_o, 0);
                @(negedge clk);
                chk("t1_grant", grant_o, 4'b0010);
                chk("t1_scyc", s_cyc_o, 1);
                chk("t1_noack", m_ack_o, 0);
                @(negedge clk);
                chk("t1_ack", m_ack_o, 4'b0010);
                chk("t1_dat", m_dat_o, rdf(32'h0000_1010));
            end
        join
        sync();

        // pointer now 2: m3 beats m0
        gq.push_back(4'b1000);
        gq.push_back(4'b0001);
        exp_beats(3, 1, 32'h0000_3000, 1'b0, 1'b0);
        exp_beats(0, 1, 32'h0000_0000, 1'b0, 1'b0);
        fork
            mrun(0, 1, 32'h0000_0000, 1'b0, 0);
            mrun(3, 1, 32'h0000_3000, 1'b0, 0);
        join
        sync();

        // all four together from pointer 0
        do_reset();
        sync();
        for (int k = 0; k < N; k++) begin
            gq.push_back(4'(1 << k));
            exp_beats(k, 1, 32'h1000_0000 + 32'(k * 'h100), 1'b0, 1'b0);
        end
        fork
            mrun(0, 1, 32'h1000_0000, 1'b0, 0);
            mrun(1, 1, 32'h1000_0100, 1'b0, 0);
            mrun(2, 1, 32'h1000_0200, 1'b0, 0);
            mrun(3, 1, 32'h1000_0300, 1'b0, 0);
        join
        sync();

        // m3 write burst, m0 waits, then wraps to m0
        gq.push_back(4'b1000);
        gq.push_back(4'b0001);
        exp_beats(3, 4, 32'h2000_0000, 1'b1, 1'b0);
        exp_beats(0, 1, 32'h2100_0000, 1'b0, 1'b0);
        fork
            mrun(3, 4, 32'h2000_0000, 1'b1, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                mrun(0, 1, 32'h2100_0000, 1'b0, 0);
            end
        join
        sync();

        // slave error to m2, grant held until m2 drops cyc
        gq.push_back(4'b0100);
        exp_beats(2, 1, 32'h3000_0040, 1'b0, 1'b1);
        err_mode = 1'b1;
        fork
            mrun(2, 1, 32'h3000_0040, 1'b0, 3);
            begin
                int i = 0;
                @(negedge clk);
                while (m_err_o == 0 && i < 50) begin
                    @(negedge clk);
                    i++;
                end
                chk("t4_err", m_err_o, 4'b0100);
                chk("t4_noack", m_ack_o, 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("t4_hold", grant_o, 4'b0100);
                end
            end
        join
        err_mode = 1'b0;
        sync();

        // hung slave
        gq.push_back(4'b0010);
        hang = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
        exp_beats(1, 1, 32'h4000_0000, 1'b0, 1'b1);
        fork
            mrun(1, 1, 32'h4000_0000, 1'b0, 0);
            begin
                int c = 0;
                wait_grant(4'b0010);
                @(negedge clk);
                c++;
                while (m_err_o == 0 && c < 100) begin
                    @(negedge clk);
                    c++;
                end
                chk("to_cycles", 64'(c), 64'(TO));
                chk("to_err", m_err_o, 4'b0010);
                chk("to_cyc_low", s_cyc_o, 0);
                @(negedge clk);
                chk("to_sticky", timeout_o, 1);
                chk("to_idle", grant_o, 0);
            end
        join
        hang = 1'b0;
`else
        fork
            mrun(1, 1, 32'h4000_0000, 1'b0, 0);
            begin
                int stuck = 0;
                wait_grant(4'b0010);
                repeat (1000) begin
                    @(negedge clk);
                    if (s_cyc_o && grant_o == 4'b0010) stuck++;
                end
                chk("hang_busy", 64'(stuck), 64'd1000);
                exp_beats(1, 1, 32'h4000_0000, 1'b0, 1'b0);
                @(posedge clk);
                #2;
                hang = 1'b0;
            end
        join
`endif
        sync();

        // async reset during a granted write
        gq.push_back(4'b0100);
        mcyc[2] = 1'b1;
        mstb[2] = 1'b1;
        mwe[2]  = 1'b1;
        madr[2] = 32'h5000_0000;
        mdat[2] = 32'h5000_0000 ^ 32'hDEAD_BEEF;
        msel[2] = 4'hB;
        wait_grant(4'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_scyc", s_cyc_o, 0);
        chk("t6_sstb", s_stb_o, 0);
        chk("t6_swe", s_we_o, 0);
        chk("t6_ssel", s_sel_o, 0);
        chk("t6_sadr", s_adr_o, 0);
        chk("t6_sdat", s_dat_o, 0);
        chk("t6_grant", grant_o, 0);
        chk("t6_mdat", m_dat_o, 0);
        mcyc[2] = 1'b0;
        mstb[2] = 1'b0;
        mwe[2]  = 1'b0;
        @(posedge clk);
        #2;
        chk("t6_ack", m_ack_o, 0);
        chk("t6_err", m_err_o, 0);
        rst_n = 1'b1;
        sync();
        sync();

        // pointer back at 0: m0 before m3
        gq.push_back(4'b0001);
        gq.push_back(4'b1000);
        exp_beats(0, 1, 32'h6000_0000, 1'b0, 1'b0);
        exp_beats(3, 1, 32'h6300_0000, 1'b0, 1'b0);
        fork
            mrun(0, 1, 32'h6000_0000, 1'b0, 0);
            mrun(3, 1, 32'h6300_0000, 1'b0, 0);
        join
        sync();
        sync();

        chk("sb_empty", 64'(sbq.size()), 0);
        chk("gq_empty", 64'(gq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
